// File: rtl/biriscv_div_sched.sv
// ---------------------------------------------------------------------------------------------
// biriscv_div_sched
// Shares one iterative out-of-pipe divider between the two issue pipes.
// Requests are arbitrated round-robin in IDLE. The winner's operands are latched and the
// divider is given a one-cycle start pulse. The result is held until the writeback port takes
// it. The divider cannot abort, so an operation that is flushed after it starts is drained:
// its completion is waited for and the result is thrown away.
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   reqN_valid_i/rd_i/opcode_i/
//   reqN_ra_i/rb_i (N = 0,1)         divide request from issue pipe N
//   reqN_accept_o                    combinational grant; the losing pipe holds its request
//   flush_i                          pipeline squash
//   div_valid_o/opcode_o/ra_o/rb_o   start pulse and latched operands to the divider
//   div_complete_i/div_result_i      divider done pulse and its result
//   wb_valid_o/rd_o/result_o         result waiting for writeback
//   wb_accept_i                      writeback port takes the result
//   busy_o, busy_rd_o                hazard scoreboard view of the in-flight operation
//   busy_cycles_o                    saturating count of busy cycles
// ---------------------------------------------------------------------------------------------
module biriscv_div_sched #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,

   input  logic             req0_valid_i,
   input  logic [4:0]       req0_rd_i,
   input  logic [31:0]      req0_opcode_i,
   input  logic [31:0]      req0_ra_i,
   input  logic [31:0]      req0_rb_i,
   output logic             req0_accept_o,

   input  logic             req1_valid_i,
   input  logic [4:0]       req1_rd_i,
   input  logic [31:0]      req1_opcode_i,
   input  logic [31:0]      req1_ra_i,
   input  logic [31:0]      req1_rb_i,
   output logic             req1_accept_o,

   input  logic             flush_i,

   output logic             div_valid_o,
   output logic [31:0]      div_opcode_o,
   output logic [31:0]      div_ra_o,
   output logic [31:0]      div_rb_o,
   input  logic             div_complete_i,
   input  logic [31:0]      div_result_i,

   output logic             wb_valid_o,
   output logic [4:0]       wb_rd_o,
   output logic [31:0]      wb_result_o,
   input  logic             wb_accept_i,

   output logic             busy_o,
   output logic [4:0]       busy_rd_o,
   output logic [CNT_W-1:0] busy_cycles_o
);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StWb, StDrain} state_e;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;  // pipe that won the last contended grant
   logic [4:0]        rd_q, rd_d;
   logic [31:0]       opcode_q, opcode_d;
   logic [31:0]       ra_q, ra_d;
   logic [31:0]       rb_q, rb_d;
   logic [31:0]       result_q, result_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              grant0, grant1;

   // Next state, grants and operand capture
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      rd_d         = rd_q;
      opcode_d     = opcode_q;
      ra_d         = ra_q;
      rb_d         = rb_q;
      result_d     = result_q;
      grant0       = 1'b0;
      grant1       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!flush_i) begin
               // On contention the pipe that did not win last time goes first
               grant0 = req0_valid_i && (!req1_valid_i || last_grant_q);
               grant1 = req1_valid_i && (!req0_valid_i || !last_grant_q);
            end
            if (grant0) begin
               rd_d     = req0_rd_i;
               opcode_d = req0_opcode_i;
               ra_d     = req0_ra_i;
               rb_d     = req0_rb_i;
               state_d  = StIssue;
               if (req1_valid_i) last_grant_d = 1'b0;
            end else if (grant1) begin
               rd_d     = req1_rd_i;
               opcode_d = req1_opcode_i;
               ra_d     = req1_ra_i;
               rb_d     = req1_rb_i;
               state_d  = StIssue;
               if (req0_valid_i) last_grant_d = 1'b1;
            end
         end
         StIssue: begin
            // The divider has already been started, so a flush here must drain
            state_d = flush_i ? StDrain : StWait;
         end
         StWait: begin
            if (div_complete_i) begin
               if (flush_i || rd_q == 5'd0) begin
                  state_d = StIdle;
               end else begin
                  result_d = div_result_i;
                  state_d  = StWb;
               end
            end else if (flush_i) begin
               state_d = StDrain;
            end
         end
         StWb: begin
            // A flush beats a simultaneous writeback accept
            if (flush_i || wb_accept_i) state_d = StIdle;
         end
         StDrain: begin
            if (div_complete_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Busy counter saturates instead of wrapping
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != StIdle && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         rd_q         <= '0;
         opcode_q     <= '0;
         ra_q         <= '0;
         rb_q         <= '0;
         result_q     <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rd_q         <= rd_d;
         opcode_q     <= opcode_d;
         ra_q         <= ra_d;
         rb_q         <= rb_d;
         result_q     <= result_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      req0_accept_o = grant0;
      req1_accept_o = grant1;
      div_valid_o   = (state_q == StIssue);
      div_opcode_o  = opcode_q;
      div_ra_o      = ra_q;
      div_rb_o      = rb_q;
      wb_valid_o    = (state_q == StWb);
      wb_rd_o       = wb_valid_o ? rd_q : 5'd0;
      wb_result_o   = wb_valid_o ? result_q : 32'd0;
      busy_o        = (state_q != StIdle);
      // A draining op never writes back, so it holds no register hazard
      busy_rd_o     = (state_q == StIssue || state_q == StWait || state_q == StWb) ? rd_q : 5'd0;
      busy_cycles_o = cnt_q;
   end

endmodule

// File: tb/tb_biriscv_div_sched.sv
module tb_biriscv_div_sched;

   localparam logic [31:0] OP_DIV  = 32'h0200_4033;
   localparam logic [31:0] OP_DIVU = 32'h0200_5033;
   localparam logic [31:0] OP_REM  = 32'h0200_6033;
   localparam logic [31:0] OP_REMU = 32'h0200_7033;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, acc0, acc1, flush;
   logic [4:0]  req0_rd, req1_rd;
   logic [31:0] req0_op, req0_ra, req0_rb, req1_op, req1_ra, req1_rb;
   logic        div_valid, div_cmp, wb_valid, wb_acc, busy;
   logic [31:0] div_op, div_ra, div_rb, div_res, wb_res;
   logic [4:0]  wb_rd, busy_rd;
   logic [15:0] busy_cycles;
   // Narrow-counter instance sharing the same stimulus
   logic        s_acc0, s_acc1, s_div_valid, s_wb_valid, s_busy;
   logic [31:0] s_div_op, s_div_ra, s_div_rb, s_wb_res;
   logic [4:0]  s_wb_rd, s_busy_rd;
   logic [3:0]  s_busy_cycles;

   always #5 clk = ~clk;

   biriscv_div_sched #(.CNT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(req0_valid), .req0_rd_i(req0_rd), .req0_opcode_i(req0_op),
      .req0_ra_i(req0_ra), .req0_rb_i(req0_rb), .req0_accept_o(acc0),
      .req1_valid_i(req1_valid), .req1_rd_i(req1_rd), .req1_opcode_i(req1_op),
      .req1_ra_i(req1_ra), .req1_rb_i(req1_rb), .req1_accept_o(acc1),
      .flush_i(flush),
      .div_valid_o(div_valid), .div_opcode_o(div_op), .div_ra_o(div_ra), .div_rb_o(div_rb),
      .div_complete_i(div_cmp), .div_result_i(div_res),
      .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_result_o(wb_res), .wb_accept_i(wb_acc),
      .busy_o(busy), .busy_rd_o(busy_rd), .busy_cycles_o(busy_cycles)
   );

   biriscv_div_sched #(.CNT_W(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .req0_valid_i(req0_valid), .req0_rd_i(req0_rd), .req0_opcode_i(req0_op),
      .req0_ra_i(req0_ra), .req0_rb_i(req0_rb), .req0_accept_o(s_acc0),
      .req1_valid_i(req1_valid), .req1_rd_i(req1_rd), .req1_opcode_i(req1_op),
      .req1_ra_i(req1_ra), .req1_rb_i(req1_rb), .req1_accept_o(s_acc1),
      .flush_i(flush),
      .div_valid_o(s_div_valid), .div_opcode_o(s_div_op), .div_ra_o(s_div_ra),
      .div_rb_o(s_div_rb), .div_complete_i(div_cmp), .div_result_i(div_res),
      .wb_valid_o(s_wb_valid), .wb_rd_o(s_wb_rd), .wb_result_o(s_wb_res), .wb_accept_i(wb_acc),
      .busy_o(s_busy), .busy_rd_o(s_busy_rd), .busy_cycles_o(s_busy_cycles)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 50)
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // RISC-V M-extension divide semantics, including divide-by-zero and overflow
   function automatic logic [31:0] div_ref(input logic [31:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa, sb;
      logic ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
      case (op[13:12])
         2'b00:   return (b == 0) ? 32'hffff_ffff : ovf ? 32'h8000_0000 : 32'(sa / sb);
         2'b01:   return (b == 0) ? 32'hffff_ffff : a / b;
         2'b10:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " acc0"}, acc0, 0);
      chk({tag, " acc1"}, acc1, 0);
      chk({tag, " div_valid"}, div_valid, 0);
      chk({tag, " div_opcode"}, div_op, 0);
      chk({tag, " div_ra"}, div_ra, 0);
      chk({tag, " div_rb"}, div_rb, 0);
      chk({tag, " wb_valid"}, wb_valid, 0);
      chk({tag, " wb_rd"}, wb_rd, 0);
      chk({tag, " wb_result"}, wb_res, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " busy_rd"}, busy_rd, 0);
      chk({tag, " busy_cycles"}, busy_cycles, 0);
      chk({tag, " busy_cycles4"}, s_busy_cycles, 0);
   endtask

   // ------------------------------------------------------------------ directed table
   typedef struct {
      bit          r0, r1, fl, cm, wa;
      logic [31:0] res;
      bit          a0, a1, dv, wv, bz;
      logic [4:0]  brd, wrd;
      logic [31:0] wres;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r0, input bit r1, input bit fl, input bit cm, input bit wa,
                      input logic [31:0] res, input bit a0, input bit a1, input bit dv,
                      input bit wv, input bit bz, input logic [4:0] brd, input logic [4:0] wrd,
                      input logic [31:0] wres);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.fl = fl; v.cm = cm; v.wa = wa; v.res = res;
      v.a0 = a0; v.a1 = a1; v.dv = dv; v.wv = wv; v.bz = bz;
      v.brd = brd; v.wrd = wrd; v.wres = wres;
      tbl.push_back(v);
   endtask

   // ------------------------------------------------------------------ reference model
   typedef enum int {MIdle, MIssue, MWait, MWb, MDrain} mst_t;
   mst_t        m_st;
   bit          m_last;        // 1: pipe1 won the last contended grant
   int          m_cnt;
   logic [4:0]  m_rd;
   logic [31:0] m_op, m_ra, m_rb, m_res;
   bit          e_a0, e_a1;

   task automatic model_grant();
      int winner;
      winner = -1;
      e_a0 = 0;
      e_a1 = 0;
      if (m_st == MIdle && !flush) begin
         if (req0_valid && req1_valid) winner = m_last ? 0 : 1;
         else if (req0_valid) winner = 0;
         else if (req1_valid) winner = 1;
      end
      if (winner == 0) e_a0 = 1;
      if (winner == 1) e_a1 = 1;
   endtask

   task automatic model_step();
      if (m_st != MIdle) m_cnt++;
      case (m_st)
         MIdle: begin
            if (e_a0 || e_a1) begin
               if (req0_valid && req1_valid) m_last = e_a1;
               m_rd  = e_a0 ? req0_rd : req1_rd;
               m_op  = e_a0 ? req0_op : req1_op;
               m_ra  = e_a0 ? req0_ra : req1_ra;
               m_rb  = e_a0 ? req0_rb : req1_rb;
               m_res = div_ref(m_op, m_ra, m_rb);
               m_st  = MIssue;
            end
         end
         MIssue: m_st = flush ? MDrain : MWait;
         MWait: begin
            if (div_cmp) m_st = (!flush && m_rd != 0) ? MWb : MIdle;
            else if (flush) m_st = MDrain;
         end
         MWb:    if (flush || wb_acc) m_st = MIdle;
         MDrain: if (div_cmp) m_st = MIdle;
         default: m_st = MIdle;
      endcase
   endtask

   task automatic gen_req(output logic [4:0] rd, output logic [31:0] op,
                          output logic [31:0] a, output logic [31:0] b);
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      case ($urandom_range(0, 3))
         0:       op = OP_DIV;
         1:       op = OP_DIVU;
         2:       op = OP_REM;
         default: op = OP_REMU;
      endcase
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      case ($urandom_range(0, 7))
         0:       b = 32'd0;
         1:       begin a = 32'h8000_0000; b = 32'hffff_ffff; end
         2, 3:    b = 32'($urandom_range(1, 50));
         default: b = $urandom;
      endcase
   endtask

   initial begin
      int tally;
      int bfm_cnt;
      logic [31:0] bfm_res;
      bit p0, p1;
      logic [31:0] e_ra;
      logic [4:0] e_brd;

      rst_n = 0;
      req0_valid = 0; req1_valid = 0; flush = 0; div_cmp = 0; div_res = 0; wb_acc = 0;
      req0_rd = 5'd5; req0_op = OP_DIV;  req0_ra = 32'd100; req0_rb = 32'd7;
      req1_rd = 5'd9; req1_op = OP_DIVU; req1_ra = 32'd50;  req1_rb = 32'd5;

      // r0 r1 fl cm wa res       a0 a1 dv wv bz brd wrd wres
      add(1, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0);    // single op, req0 first
      add(0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 5, 0, 0);
      add(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 5, 0, 0);
      add(0, 0, 0, 1, 0, 14,      0, 0, 0, 0, 1, 5, 0, 0);
      add(0, 0, 0, 0, 0, 0,       0, 0, 0, 1, 1, 5, 5, 14);
      add(0, 0, 0, 0, 1, 0,       0, 0, 0, 1, 1, 5, 5, 14);
      add(0, 0, 0, 1, 0, 99,      0, 0, 0, 0, 0, 0, 0, 0);    // stray complete in idle
      add(1, 1, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0);    // contention: 0,1,0
      add(0, 1, 0, 0, 0, 0,       0, 0, 1, 0, 1, 5, 0, 0);
      add(0, 1, 0, 1, 0, 14,      0, 0, 0, 0, 1, 5, 0, 0);
      add(0, 1, 0, 0, 1, 0,       0, 0, 0, 1, 1, 5, 5, 14);
      add(1, 1, 0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 9, 0, 0);
      add(1, 0, 0, 1, 0, 10,      0, 0, 0, 0, 1, 9, 0, 0);
      add(1, 0, 0, 0, 1, 0,       0, 0, 0, 1, 1, 9, 9, 10);
      add(1, 1, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0,       0, 0, 1, 0, 1, 5, 0, 0);
      add(0, 0, 1, 0, 0, 0,       0, 0, 0, 0, 1, 5, 0, 0);    // flush in WAIT -> drain
      add(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 14,      0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0);    // flush blocks accept
      add(1, 0, 0, 0, 0, 0,       1, 0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,       0, 0, 1, 0, 1, 5, 0, 0);
      add(0, 0, 0, 1, 0, 77,      0, 0, 0, 0, 1, 5, 0, 0);
      for (int k = 0; k < 10; k++)                               // writeback stalled
         add(0, 0, 0, 0, 0, 32'hdead_0000 + 32'(k), 0, 0, 0, 1, 1, 5, 5, 77);
      add(0, 0, 1, 0, 1, 0,       0, 0, 0, 1, 1, 5, 5, 77);   // flush beats wb accept
      add(0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0);

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1;

      tally = 0;
      foreach (tbl[i]) begin
         tick();
         req0_valid = tbl[i].r0; req1_valid = tbl[i].r1; flush = tbl[i].fl;
         div_cmp = tbl[i].cm; div_res = tbl[i].res; wb_acc = tbl[i].wa;
         @(negedge clk);
         chk($sformatf("t%0d acc0", i), acc0, tbl[i].a0);
         chk($sformatf("t%0d acc1", i), acc1, tbl[i].a1);
         chk($sformatf("t%0d div_valid", i), div_valid, tbl[i].dv);
         chk($sformatf("t%0d wb_valid", i), wb_valid, tbl[i].wv);
         chk($sformatf("t%0d busy", i), busy, tbl[i].bz);
         chk($sformatf("t%0d busy_rd", i), busy_rd, tbl[i].brd);
         chk($sformatf("t%0d busy_cycles", i), busy_cycles, tally);
         if (tbl[i].dv) begin
            e_ra = (tbl[i].brd == 5'd5) ? 32'd100 : 32'd50;
            chk($sformatf("t%0d div_ra", i), div_ra, e_ra);
         end
         if (tbl[i].wv) begin
            chk($sformatf("t%0d wb_rd", i), wb_rd, tbl[i].wrd);
            chk($sformatf("t%0d wb_result", i), wb_res, tbl[i].wres);
         end
         if (tbl[i].bz) tally++;
      end

      // rd=0 divide: no writeback, busy for the issue cycle plus three wait cycles
      tick();
      req0_rd = 5'd0; req0_valid = 1; div_cmp = 0; flush = 0; wb_acc = 0;
      @(negedge clk);
      chk("rd0 accept", acc0, 1);
      tick();
      req0_valid = 0;
      @(negedge clk);
      chk("rd0 div_valid", div_valid, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         div_cmp = (k == 2); div_res = 32'd14;
         @(negedge clk);
         chk("rd0 busy", busy, 1);
         chk("rd0 busy_rd", busy_rd, 0);
         chk("rd0 wb_valid", wb_valid, 0);
      end
      tick();
      div_cmp = 0;
      @(negedge clk);
      chk("rd0 idle", busy, 0);
      chk("rd0 no wb", wb_valid, 0);
      chk("rd0 busy_cycles", busy_cycles, tally + 4);
      tally += 4;

      // Long op: narrow counter saturates, then reset lands mid-WAIT
      tick();
      req0_rd = 5'd3; req0_valid = 1;
      @(negedge clk);
      chk("long accept", acc0, 1);
      tick();
      req0_valid = 0;
      for (int k = 0; k < 20; k++) tick();
      @(negedge clk);
      chk("long sat4", s_busy_cycles, 15);
      chk("long busy_cycles", busy_cycles, tally + 20);
      chk("long busy_rd", busy_rd, 3);
      #2 rst_n = 0;
      #1 check_all_zero("async reset");

      // Randomised run against the reference model
      m_st = MIdle; m_last = 1; m_cnt = 0; m_rd = 0; m_op = 0; m_ra = 0; m_rb = 0; m_res = 0;
      bfm_cnt = 0; bfm_res = 0; p0 = 0; p1 = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         tick();
         if (!p0 && $urandom_range(0, 2) == 0) begin
            p0 = 1;
            gen_req(req0_rd, req0_op, req0_ra, req0_rb);
         end
         if (!p1 && $urandom_range(0, 2) == 0) begin
            p1 = 1;
            gen_req(req1_rd, req1_op, req1_ra, req1_rb);
         end
         req0_valid = p0;
         req1_valid = p1;
         flush  = ($urandom_range(0, 9) == 0);
         wb_acc = ($urandom_range(0, 1) == 0);
         div_cmp = 0;
         div_res = $urandom;
         if (bfm_cnt > 0) begin
            bfm_cnt--;
            if (bfm_cnt == 0) begin
               div_cmp = 1;
               div_res = bfm_res;
            end
         end else if ((m_st == MIdle || m_st == MWb) && $urandom_range(0, 9) == 0) begin
            div_cmp = 1;
         end
         @(negedge clk);
         model_grant();
         e_brd = (m_st == MIssue || m_st == MWait || m_st == MWb) ? m_rd : 5'd0;
         chk("rnd acc0", acc0, e_a0);
         chk("rnd acc1", acc1, e_a1);
         chk("rnd div_valid", div_valid, m_st == MIssue);
         chk("rnd wb_valid", wb_valid, m_st == MWb);
         chk("rnd busy", busy, m_st != MIdle);
         chk("rnd busy_rd", busy_rd, e_brd);
         chk("rnd busy_cycles", busy_cycles, (m_cnt > 65535) ? 65535 : m_cnt);
         chk("rnd busy_cycles4", s_busy_cycles, (m_cnt > 15) ? 15 : m_cnt);
         if (m_st == MIssue) begin
            chk("rnd div_opcode", div_op, m_op);
            chk("rnd div_ra", div_ra, m_ra);
            chk("rnd div_rb", div_rb, m_rb);
         end
         if (m_st == MWb) begin
            chk("rnd wb_rd", wb_rd, m_rd);
            chk("rnd wb_result", wb_res, m_res);
         end
         // Environment reacts to what the DUT actually did
         if (acc0) p0 = 0;
         if (acc1) p1 = 0;
         if (div_valid) begin
            bfm_cnt = $urandom_range(1, 6);
            bfm_res = div_ref(div_op, div_ra, div_rb);
         end
         model_step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
